// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle MIPS main control FSM.
package multicycle_control_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_type;

  typedef logic [3:0] ctrl_state_t;

  localparam ctrl_state_t S_FETCH  = 4'd0;
  localparam ctrl_state_t S_DECODE = 4'd1;
  localparam ctrl_state_t S_MEMADR = 4'd2;
  localparam ctrl_state_t S_MEMRD  = 4'd3;
  localparam ctrl_state_t S_MEMWB  = 4'd4;
  localparam ctrl_state_t S_MEMWR  = 4'd5;
  localparam ctrl_state_t S_EXEC   = 4'd6;
  localparam ctrl_state_t S_ALUWB  = 4'd7;
  localparam ctrl_state_t S_BRANCH = 4'd8;
  localparam ctrl_state_t S_ADDIEX = 4'd9;
  localparam ctrl_state_t S_ADDIWB = 4'd10;
  localparam ctrl_state_t S_JUMP   = 4'd11;
  localparam ctrl_state_t S_FAULT  = 4'd12;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU      = 2'b00;
  localparam logic [1:0] PC_ALUOUT   = 2'b01;
  localparam logic [1:0] PC_JUMP     = 2'b10;

  // States that wait on the memory handshake and are guarded by the timer.
  function automatic logic is_mem_wait_state(input ctrl_state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_ctrl_wait_timer.sv
// Counts consecutive memory wait cycles; flags the cycle on which the limit is hit.
module multicycle_control_ctrl_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  if (MAX_WAIT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] count_q;

    // count_q holds the number of earlier wait cycles, so the MAX_WAIT-th one expires.
    assign expired = tick && (count_q == LAST);

    // Wait counter: cleared outside wait states or on ready, advances on each stalled cycle.
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        count_q <= '0;
      end else if (tick && !expired) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory wait timeout and retire counter.
module multicycle_control #(
  parameter bit          HAS_ADDI = 1'b1,
  parameter bit          HAS_JUMP = 1'b1,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             retired,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             fault
);
  import multicycle_control_pkg::*;

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             in_wait, wait_tick, wait_clear, wait_expired;

  assign in_wait    = is_mem_wait_state(state_q);
  assign wait_tick  = in_wait && !mem_ready;
  assign wait_clear = !in_wait || mem_ready;

  multicycle_control_ctrl_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (wait_clear),
    .tick   (wait_tick),
    .expired(wait_expired)
  );

  // Next-state logic; ready beats timeout when both land on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)         state_d = S_DECODE;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = HAS_ADDI ? S_ADDIEX : S_FAULT;
          OP_J:         state_d = HAS_JUMP ? S_JUMP : S_FAULT;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)         state_d = S_MEMWB;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_MEMWR: begin
        if (mem_ready)         state_d = S_FETCH;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  // State register and retire counter; reset overrides any pending handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retired) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign retire_cnt = cnt_q;

  // Output decode: everything defaults low, each state raises only its own controls.
  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALUOP_ADD;
    pc_src     = PC_ALU;
    pc_en      = 1'b0;
    retired    = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retired    = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retired   = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PC_ALUOUT;
        pc_en     = zero;
        retired   = 1'b1;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      S_JUMP: begin
        pc_src  = PC_JUMP;
        pc_en   = 1'b1;
        retired = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: cycle table on the default build, hand sequences on a
// reduced build (no J, MAX_WAIT=4, 2-bit counter).
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg, a_reg_write;
  logic a_alu_src_a, a_pc_en, a_retired, a_fault;
  logic [1:0] a_alu_src_b, a_alu_op, a_pc_src;
  logic [15:0] a_retire_cnt;

  logic b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg, b_reg_write;
  logic b_alu_src_a, b_pc_en, b_retired, b_fault;
  logic [1:0] b_alu_src_b, b_alu_op, b_pc_src;
  logic [1:0] b_retire_cnt;

  logic [16:0] a_ctl, b_ctl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control u_dut_a (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(a_iord), .mem_read(a_mem_read), .mem_write(a_mem_write), .ir_write(a_ir_write),
    .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .pc_src(a_pc_src),
    .pc_en(a_pc_en), .retired(a_retired), .retire_cnt(a_retire_cnt), .fault(a_fault)
  );

  multicycle_control #(
    .HAS_ADDI(1'b1), .HAS_JUMP(1'b0), .MAX_WAIT(4), .CNT_W(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .pc_src(b_pc_src),
    .pc_en(b_pc_en), .retired(b_retired), .retire_cnt(b_retire_cnt), .fault(b_fault)
  );

  assign a_ctl = {a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg,
                  a_reg_write, a_alu_src_a, a_alu_src_b, a_alu_op, a_pc_src, a_pc_en,
                  a_retired, a_fault};
  assign b_ctl = {b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg,
                  b_reg_write, b_alu_src_a, b_alu_src_b, b_alu_op, b_pc_src, b_pc_en,
                  b_retired, b_fault};

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [16:0] ctl;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [16:0] mk(input logic iord, mr, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, aop, ps,
                                     input logic pen, ret, flt);
    return {iord, mr, mw, irw, rd, m2r, rw, sa, sb, aop, ps, pen, ret, flt};
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic z, input logic rdy,
                     input logic [16:0] ctl, input logic [15:0] cnt);
    vec_t v;
    v.r = r; v.op = o; v.z = z; v.rdy = rdy; v.ctl = ctl; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic drive(input logic r, input logic [5:0] o, input logic z, input logic rdy);
    @(negedge clk);
    rst = r; op = o; zero = z; mem_ready = rdy;
    #2;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  logic [16:0] e_f, e_fr, e_dec, e_ma, e_mrd, e_mwb, e_mwr, e_mwrr;
  logic [16:0] e_ex, e_awb, e_br1, e_br0, e_aiwb, e_j, e_flt;

  initial begin
    e_f    = mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    e_fr   = mk(0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0);
    e_dec  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0);
    e_ma   = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
    e_mrd  = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    e_mwb  = mk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
    e_mwr  = mk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    e_mwrr = mk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
    e_ex   = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    e_awb  = mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
    e_br1  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 1, 0);
    e_br0  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 1, 0);
    e_aiwb = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
    e_j    = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 1, 0);
    e_flt  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);

    // LW: 5 cycles, first row also checks the post-reset state and count.
    add(0, 6'h23, 0, 1, e_fr, 0);  add(0, 6'h23, 0, 0, e_dec, 0);
    add(0, 6'h23, 0, 0, e_ma, 0);  add(0, 6'h23, 0, 1, e_mrd, 0);
    add(0, 6'h23, 0, 0, e_mwb, 0);
    // SW with three stalled cycles in MEMWR.
    add(0, 6'h2B, 0, 1, e_fr, 1);  add(0, 6'h2B, 0, 0, e_dec, 1);
    add(0, 6'h2B, 0, 0, e_ma, 1);  add(0, 6'h2B, 0, 0, e_mwr, 1);
    add(0, 6'h2B, 0, 0, e_mwr, 1); add(0, 6'h2B, 0, 0, e_mwr, 1);
    add(0, 6'h2B, 0, 1, e_mwrr, 1);
    // BEQ taken then not taken.
    add(0, 6'h04, 1, 1, e_fr, 2);  add(0, 6'h04, 1, 0, e_dec, 2);
    add(0, 6'h04, 1, 0, e_br1, 2);
    add(0, 6'h04, 0, 1, e_fr, 3);  add(0, 6'h04, 0, 0, e_dec, 3);
    add(0, 6'h04, 0, 0, e_br0, 3);
    // RTYPE, ADDI, J.
    add(0, 6'h00, 0, 1, e_fr, 4);  add(0, 6'h00, 0, 0, e_dec, 4);
    add(0, 6'h00, 0, 0, e_ex, 4);  add(0, 6'h00, 0, 0, e_awb, 4);
    add(0, 6'h08, 0, 1, e_fr, 5);  add(0, 6'h08, 0, 0, e_dec, 5);
    add(0, 6'h08, 0, 0, e_ma, 5);  add(0, 6'h08, 0, 0, e_aiwb, 5);
    add(0, 6'h02, 0, 1, e_fr, 6);  add(0, 6'h02, 0, 0, e_dec, 6);
    add(0, 6'h02, 0, 0, e_j, 6);
    // Fetch stalls twice, then illegal opcode faults; only reset leaves FAULT.
    add(0, 6'h3F, 0, 0, e_f, 7);   add(0, 6'h3F, 0, 0, e_f, 7);
    add(0, 6'h3F, 0, 1, e_fr, 7);  add(0, 6'h3F, 0, 0, e_dec, 7);
    add(0, 6'h3F, 0, 0, e_flt, 7); add(0, 6'h3F, 0, 1, e_flt, 7);
    add(1, 6'h00, 0, 0, e_flt, 7); add(0, 6'h00, 0, 1, e_fr, 0);

    drive(1, 6'h00, 0, 0);
    drive(1, 6'h00, 0, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].op, vecs[i].z, vecs[i].rdy);
      chk("ctl", i, 32'(a_ctl), 32'(vecs[i].ctl));
      chk("retire_cnt", i, 32'(a_retire_cnt), 32'(vecs[i].cnt));
    end

    // J with HAS_JUMP=0 faults after DECODE; the full build jumps.
    drive(1, 6'h00, 0, 0);
    drive(0, 6'h02, 0, 1); chk("nojump_irw", 0, 32'(b_ir_write), 1);
    drive(0, 6'h02, 0, 0); chk("nojump_dec", 0, 32'(b_alu_src_b), 3);
    drive(0, 6'h02, 0, 1); chk("jump_pcsrc", 0, 32'(a_pc_src), 2);
    chk("nojump_fault", 0, 32'(b_fault), 1);
    for (int k = 1; k < 3; k++) begin
      drive(0, 6'h02, 0, 1);
      chk("nojump_fault", k, 32'(b_fault), 1);
      chk("nojump_pcen", k, 32'(b_pc_en), 0);
    end
    drive(1, 6'h00, 0, 0);
    drive(0, 6'h00, 0, 0); chk("nojump_rst", 0, 32'(b_ctl), 32'(e_f));

    // MAX_WAIT=4: four stalled fetch cycles, then FAULT.
    drive(1, 6'h00, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 6'h00, 0, 0);
      chk("to_wait", k, 32'(b_ctl), 32'(e_f));
    end
    drive(0, 6'h00, 0, 0);
    chk("to_fault", 0, 32'(b_ctl), 32'(e_flt));
    chk("to_long", 0, 32'(a_ctl), 32'(e_f));

    // Ready on the 4th stalled cycle completes the fetch.
    drive(1, 6'h00, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 6'h00, 0, 0);
    drive(0, 6'h00, 0, 1); chk("to_ready", 0, 32'(b_ctl), 32'(e_fr));
    drive(0, 6'h00, 0, 0); chk("to_decode", 0, 32'(b_ctl), 32'(e_dec));

    // CNT_W=2: four RTYPEs, count wraps 3 -> 0.
    drive(1, 6'h00, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 6'h00, 0, 1);
      chk("wrap_cnt", k, 32'(b_retire_cnt), 32'(k));
      drive(0, 6'h00, 0, 0);
      drive(0, 6'h00, 0, 0);
      drive(0, 6'h00, 0, 0); chk("wrap_ret", k, 32'(b_retired), 1);
    end
    drive(0, 6'h00, 0, 0); chk("wrap_cnt", 4, 32'(b_retire_cnt), 0);

    // Reset while in MEMRD with ready high: back to FETCH, no write-back.
    drive(1, 6'h00, 0, 0);
    drive(0, 6'h23, 0, 1);
    drive(0, 6'h23, 0, 0);
    drive(0, 6'h23, 0, 0);
    drive(1, 6'h23, 0, 1); chk("rstmid_memrd", 0, 32'(a_ctl), 32'(e_mrd));
    drive(0, 6'h23, 0, 0); chk("rstmid_fetch", 0, 32'(a_ctl), 32'(e_f));
    chk("rstmid_cnt", 0, 32'(a_retire_cnt), 0);
    drive(0, 6'h23, 0, 0); chk("rstmid_norw", 0, 32'(a_reg_write), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
